// File: rtl/pll_dynphase_ctrl.sv
// Dynamic-phase and reset sequencer for an ECP5 EHXPLLL: power-up reset, lock
// qualification, lock-loss recovery and multi-step PHASESTEP requests per output.
module pll_dynphase_ctrl #(
  parameter int unsigned NUM_OUT       = 4,
  parameter int unsigned STEP_WIDTH    = 4,
  parameter int unsigned POS_WIDTH     = 6,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pll_locked,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_chan,
  input  logic                           req_dir,
  input  logic [STEP_WIDTH-1:0]          req_steps,
  output logic                           done,
  output logic                           err,
  output logic                           pll_rst,
  output logic [1:0]                     phasesel,
  output logic                           phasedir,
  output logic                           phasestep,
  output logic                           phaseloadreg,
  output logic                           pll_ready,
  output logic [NUM_OUT*POS_WIDTH-1:0]   phase_pos,
  output logic [7:0]                     lock_loss_cnt
);

  localparam int unsigned CntMax = LOCK_STABLE + RST_CYCLES + SETUP_CYCLES + PULSE_CYCLES +
                                   SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [2:0] {
    StRstHold, StWaitLock, StIdle, StSetup, StPulse, StSettle
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [1:0]            sel_q, sel_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [7:0]            loss_q, loss_d;
  logic [POS_WIDTH-1:0]  pos_q [NUM_OUT];
  logic [POS_WIDTH-1:0]  pos_d [NUM_OUT];
  logic                  lock_s1_q, lock_s_q;
  logic                  active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      lock_s1_q <= pll_locked;
      lock_s_q  <= lock_s1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRstHold;
      cnt_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      loss_q  <= '0;
      for (int c = 0; c < NUM_OUT; c++) pos_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
      pos_q   <= pos_d;
    end
  end

  assign active = (state_q == StIdle) || (state_q == StSetup) ||
                  (state_q == StPulse) || (state_q == StSettle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    loss_d  = loss_q;
    pos_d   = pos_q;
    if (active && !lock_s_q) begin
      // A PLL reset restores the static phases, so tracked positions restart at zero.
      state_d = StRstHold;
      cnt_d   = '0;
      if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
      for (int c = 0; c < NUM_OUT; c++) pos_d[c] = '0;
    end else begin
      case (state_q)
        StRstHold: begin
          if (cnt_q == CntW'(RST_CYCLES - 1)) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitLock: begin
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(LOCK_STABLE - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StIdle: begin
          if (req_valid) begin
            if ({30'd0, req_chan} >= NUM_OUT) begin
              err_d = 1'b1;
            end else if (req_steps == '0) begin
              done_d = 1'b1;
            end else begin
              sel_d   = req_chan;
              dir_d   = req_dir;
              steps_d = req_steps;
              cnt_d   = '0;
              state_d = StSetup;
            end
          end
        end
        StSetup: begin
          if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
            state_d = StPulse;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPulse: begin
          if (cnt_q == CntW'(PULSE_CYCLES - 1)) begin
            state_d = StSettle;
            cnt_d   = '0;
            steps_d = steps_q - STEP_WIDTH'(1);
            for (int c = 0; c < NUM_OUT; c++) begin
              if (sel_q == 2'(c)) begin
                pos_d[c] = dir_q ? pos_q[c] + POS_WIDTH'(1) : pos_q[c] - POS_WIDTH'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            cnt_d = '0;
            if (steps_q != '0) begin
              state_d = StSetup;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StRstHold;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pin-level outputs decode the state directly so reset or abort releases PHASESTEP at once.
  always_comb begin
    phase_pos = '0;
    for (int c = 0; c < NUM_OUT; c++) phase_pos[c*POS_WIDTH +: POS_WIDTH] = pos_q[c];
  end

  assign pll_rst       = (state_q == StRstHold);
  assign phasestep     = (state_q != StPulse);
  assign phaseloadreg  = 1'b1;
  assign phasesel      = sel_q;
  assign phasedir      = dir_q;
  assign req_ready     = (state_q == StIdle);
  assign pll_ready     = active;
  assign done          = done_q;
  assign err           = err_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_dynphase_ctrl.sv
// Directed bench for pll_dynphase_ctrl: power-up, request vectors, error/edge requests,
// lock loss with requalification glitch, and asynchronous reset mid-pulse.
module tb_pll_dynphase_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pll_locked = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic [1:0]  req_chan = '0;
  logic        req_dir = 1'b0;
  logic [3:0]  req_steps = '0;

  logic        req_ready, done, err, pll_rst, phasedir, phasestep, phaseloadreg, pll_ready;
  logic [1:0]  phasesel;
  logic [23:0] phase_pos;
  logic [7:0]  lock_loss_cnt;

  logic        req_ready2, done2, err2, pll_rst2, phasedir2, phasestep2, phaseloadreg2;
  logic        pll_ready2;
  logic [1:0]  phasesel2;
  logic [11:0] phase_pos2;
  logic [7:0]  lock_loss_cnt2;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  chan;
    logic        dir;
    logic [3:0]  steps;
    int          lat;
    logic [23:0] pos;
  } vec_t;

  vec_t vecs [6];

  pll_dynphase_ctrl dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan), .req_dir(req_dir),
    .req_steps(req_steps), .done(done), .err(err), .pll_rst(pll_rst),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .pll_ready(pll_ready), .phase_pos(phase_pos),
    .lock_loss_cnt(lock_loss_cnt)
  );

  pll_dynphase_ctrl #(.NUM_OUT(2)) dut2 (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_chan(req_chan), .req_dir(req_dir),
    .req_steps(req_steps), .done(done2), .err(err2), .pll_rst(pll_rst2),
    .phasesel(phasesel2), .phasedir(phasedir2), .phasestep(phasestep2),
    .phaseloadreg(phaseloadreg2), .pll_ready(pll_ready2), .phase_pos(phase_pos2),
    .lock_loss_cnt(lock_loss_cnt2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts pll_rst-high cycles starting from the current one.
  task automatic count_rst(output int n, output int dones);
    n = 0;
    dones = 0;
    while (pll_rst && n < 100) begin
      n++;
      if (done) dones++;
      @(negedge clock);
    end
  endtask

  // Raises lock and returns the cycle on which pll_ready is first seen (0 on timeout).
  task automatic qualify(input int glitch_at, output int k);
    k = 0;
    pll_locked = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clock);
      if (pll_ready) begin
        k = i;
        break;
      end
      if (glitch_at != 0 && i == glitch_at) pll_locked = 1'b0;
      if (glitch_at != 0 && i == glitch_at + 1) pll_locked = 1'b1;
    end
  endtask

  task automatic run_req(input vec_t v, input int idx);
    int lows, falls, first_fall, last_fall, lat, ready_bad;
    logic prev_ps;
    string tag;
    tag = $sformatf("vec%0d", idx);
    req_chan  = v.chan;
    req_dir   = v.dir;
    req_steps = v.steps;
    req_valid = 1'b1;
    #1;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    lows = 0; falls = 0; first_fall = 0; last_fall = 0; lat = 0; ready_bad = 0;
    prev_ps = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      if (!phasestep) begin
        lows++;
        if (prev_ps) begin
          if (falls == 0) first_fall = i;
          else check({tag, " pulse spacing"}, i - last_fall, 32'd14);
          check({tag, " phasesel"}, 32'(phasesel), 32'(v.chan));
          check({tag, " phasedir"}, 32'(phasedir), 32'(v.dir));
          last_fall = i;
          falls++;
        end
      end
      prev_ps = phasestep;
      if (done) begin
        lat = i;
        break;
      end
      if (req_ready) ready_bad++;
      @(negedge clock);
    end
    check({tag, " done latency"}, lat, v.lat);
    check({tag, " low cycles"}, lows, 4 * int'(v.steps));
    if (v.steps != 0) check({tag, " first fall"}, first_fall, 32'd3);
    check({tag, " req_ready busy"}, ready_bad, 32'd0);
    check({tag, " phase_pos"}, 32'(phase_pos), 32'(v.pos));
    @(negedge clock);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, dones, k, stray, lat;

    vecs[0] = '{2'd3, 1'b1, 4'd3, 43, {6'd3,  6'd0, 6'd0, 6'd0}};
    vecs[1] = '{2'd0, 1'b0, 4'd1, 15, {6'd3,  6'd0, 6'd0, 6'd63}};
    vecs[2] = '{2'd1, 1'b1, 4'd0, 1,  {6'd3,  6'd0, 6'd0, 6'd63}};
    vecs[3] = '{2'd2, 1'b1, 4'd2, 29, {6'd3,  6'd2, 6'd0, 6'd63}};
    vecs[4] = '{2'd3, 1'b0, 4'd5, 71, {6'd62, 6'd2, 6'd0, 6'd63}};
    vecs[5] = '{2'd0, 1'b1, 4'd1, 15, {6'd62, 6'd2, 6'd0, 6'd0}};

    repeat (3) @(negedge clock);
    check("rst pll_rst", 32'(pll_rst), 32'd1);
    check("rst phasestep", 32'(phasestep), 32'd1);
    check("rst phaseloadreg", 32'(phaseloadreg), 32'd1);
    check("rst phasesel", 32'(phasesel), 32'd0);
    check("rst phasedir", 32'(phasedir), 32'd0);
    check("rst ready flags", {28'd0, req_ready, done, err, pll_ready}, 32'd0);
    check("rst phase_pos", 32'(phase_pos), 32'd0);
    check("rst lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    // Power-up: lock arrives 5 cycles after pll_rst falls.
    reset = 1'b0;
    #1;
    count_rst(n, dones);
    check("pwr pll_rst cycles", n, 32'd16);
    repeat (5) @(negedge clock);
    qualify(0, k);
    check("pwr ready latency", k, 32'd1026);
    check("pwr req_ready", 32'(req_ready), 32'd1);

    for (int v = 0; v < 6; v++) run_req(vecs[v], v);

    // Out-of-range channels on a two-output instance.
    for (int j = 2; j <= 3; j++) begin
      req_chan   = 2'(j);
      req_dir    = 1'b1;
      req_steps  = 4'd2;
      req_valid2 = 1'b1;
      #1;
      check("err req_ready", 32'(req_ready2), 32'd1);
      @(negedge clock);
      req_valid2 = 1'b0;
      check("err pulse", 32'(err2), 32'd1);
      check("err no done", 32'(done2), 32'd0);
      check("err stays idle", 32'(req_ready2), 32'd1);
      stray = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        if (!phasestep2 || err2 || done2) stray++;
      end
      check("err no activity", stray, 32'd0);
      check("err phase_pos", 32'(phase_pos2), 32'd0);
    end

    // Valid request on the two-output instance wraps channel 1 downwards.
    req_chan = 2'd1; req_dir = 1'b0; req_steps = 4'd1; req_valid2 = 1'b1;
    @(negedge clock);
    req_valid2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done2) begin
        lat = i;
        break;
      end
      @(negedge clock);
    end
    check("dut2 latency", lat, 32'd15);
    check("dut2 phase_pos", 32'(phase_pos2), 32'h0fc0);

    // Lock drops so the synchronised lock falls in the first cycle of the second pulse.
    req_chan = 2'd1; req_dir = 1'b1; req_steps = 4'd5; req_valid = 1'b1;
    #1;
    check("ll req_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    dones = 0;
    for (int i = 1; i < 18; i++) begin
      if (done) dones++;
      if (i == 10) check("ll first step pos", 32'(phase_pos),
                         32'({6'd62, 6'd2, 6'd1, 6'd0}));
      if (i == 15) pll_locked = 1'b0;
      if (i == 17) check("ll pulse2 low", 32'(phasestep), 32'd0);
      @(negedge clock);
    end
    check("ll phasestep high", 32'(phasestep), 32'd1);
    check("ll pll_ready", 32'(pll_ready), 32'd0);
    check("ll req_ready", 32'(req_ready), 32'd0);
    check("ll lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    check("ll phase_pos zero", 32'(phase_pos), 32'd0);
    count_rst(n, k);
    check("ll pll_rst cycles", n, 32'd16);
    check("ll no done", dones + k, 32'd0);
    repeat (5) @(negedge clock);
    qualify(500, k);
    check("glitch ready latency", k, 32'd1527);
    check("glitch lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);

    // Asynchronous reset while PHASESTEP is low.
    req_chan = 2'd2; req_dir = 1'b1; req_steps = 4'd2; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        check("ar pulse low", 32'(phasestep), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("ar phasestep", 32'(phasestep), 32'd1);
        check("ar pll_rst", 32'(pll_rst), 32'd1);
        check("ar phasesel", 32'(phasesel), 32'd0);
        check("ar flags", {28'd0, req_ready, done, err, pll_ready}, 32'd0);
        check("ar lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        check("ar phase_pos", 32'(phase_pos), 32'd0);
      end else begin
        @(negedge clock);
      end
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    count_rst(n, dones);
    check("ar pll_rst cycles", n, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
